pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 6-stage in-order core (PC, IF, ID, EX, MEM, WB). It combines per-stage stall requests into the `StallBus` freeze vector. It issues the one-cycle pipeline flush on exceptions. It owns a single redirect register that holds a branch or exception target until the fetch stage accepts it.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/ctrl_perf_cnt.sv | 29 ++
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencer.
//   - StallBus width and the per-hazard freeze masks (bit 0 = PC .. bit 5 = WB)
//   - FSM state encoding for the redirect register owner
package pipe_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    // Each mask freezes the requesting stage and every stage in front of it.
    localparam logic [STALL_BUS_W-1:0] STALL_MEM    = 6'b011111;
    localparam logic [STALL_BUS_W-1:0] STALL_EX     = 6'b001111;
    localparam logic [STALL_BUS_W-1:0] STALL_LOAD   = 6'b000111;
    localparam logic [STALL_BUS_W-1:0] STALL_IFETCH = 6'b000011;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_REDIR = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_perf_cnt.sv
// ctrl_perf_cnt: 32-bit enable-driven event counter, wraps modulo 2^32.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, clears the count
//   en    in   count this cycle
//   count out  registered count value
module ctrl_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Counter register: natural 32-bit wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (en) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 6-stage in-order pipeline.
//   Combines stall requests into a per-stage freeze vector, raises a
//   one-cycle flush on exceptions and owns the redirect (new PC) register.
// Optional feature macro: PIPE_CTRL_PERF_EN builds the stall/flush
//   performance counters; without it both perf outputs are tied to 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallreq_for_ifetch/load/ex/mem  stall requests from IF, ID, EX, MEM
//   excp_valid, excp_target  exception/eret committed in MEM and its target
//   br_valid, br_target      taken branch resolved in EX and its target
//   new_pc_ready             PC stage accepts the held redirect
//   stall                    per-stage freeze vector (combinational)
//   flush                    kill in-flight IF..MEM (combinational)
//   new_pc_valid, new_pc     held redirect (registered)
//   perf_stall_cnt, perf_flush_cnt   performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          STALL_W = 6,
    parameter logic [31:0] RST_PC  = 32'hBFC0_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_for_ifetch,
    input  logic               stallreq_for_load,
    input  logic               stallreq_for_ex,
    input  logic               stallreq_for_mem,
    input  logic               excp_valid,
    input  logic [31:0]        excp_target,
    input  logic               br_valid,
    input  logic [31:0]        br_target,
    input  logic               new_pc_ready,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               new_pc_valid,
    output logic [31:0]        new_pc,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
);

    localparam logic [STALL_W-1:0] REDIR_FORCE = {{(STALL_W-2){1'b0}}, 2'b11};

    ctrl_state_e        state_r;
    logic [31:0]        redir_pc_r;
    logic [STALL_W-1:0] mask_s;
    logic [STALL_W-1:0] stall_s;
    logic               br_accept_s;

    // Priority stall mask: the deepest requesting stage wins.
    always_comb begin
        mask_s = {STALL_W{1'b0}};
        if (stallreq_for_mem) begin
            mask_s = STALL_W'(STALL_MEM);
        end else if (stallreq_for_ex) begin
            mask_s = STALL_W'(STALL_EX);
        end else if (stallreq_for_load) begin
            mask_s = STALL_W'(STALL_LOAD);
        end else if (stallreq_for_ifetch) begin
            mask_s = STALL_W'(STALL_IFETCH);
        end else begin
            mask_s = {STALL_W{1'b0}};
        end
    end

    // Final freeze vector. PC/IF are held while a redirect is outstanding,
    // keyed off the registered state so new_pc_ready never reaches stall.
    // A flush releases every stage so the killed bubbles can drain.
    always_comb begin
        stall_s = {STALL_W{1'b0}};
        if (excp_valid) begin
            stall_s = {STALL_W{1'b0}};
        end else if (state_r == CTRL_REDIR) begin
            stall_s = mask_s | REDIR_FORCE;
        end else begin
            stall_s = mask_s;
        end
    end

    // A branch is only taken when EX is actually advancing; otherwise EX
    // re-presents it, and during REDIR it is on the wrong path.
    assign br_accept_s = (state_r == CTRL_IDLE) & ~excp_valid & br_valid & ~stall_s[3];

    // Redirect FSM: an exception always supersedes whatever target is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= CTRL_IDLE;
            redir_pc_r <= RST_PC;
        end else begin
            case (state_r)
                CTRL_IDLE: begin
                    if (excp_valid) begin
                        state_r    <= CTRL_REDIR;
                        redir_pc_r <= excp_target;
                    end else if (br_accept_s) begin
                        state_r    <= CTRL_REDIR;
                        redir_pc_r <= br_target;
                    end else begin
                        state_r    <= CTRL_IDLE;
                        redir_pc_r <= redir_pc_r;
                    end
                end
                CTRL_REDIR: begin
                    if (excp_valid) begin
                        state_r    <= CTRL_REDIR;
                        redir_pc_r <= excp_target;
                    end else if (new_pc_ready) begin
                        // Target delivered; new_pc returns to its idle value.
                        state_r    <= CTRL_IDLE;
                        redir_pc_r <= RST_PC;
                    end else begin
                        state_r    <= CTRL_REDIR;
                        redir_pc_r <= redir_pc_r;
                    end
                end
                default: begin
                    state_r    <= CTRL_IDLE;
                    redir_pc_r <= RST_PC;
                end
            endcase
        end
    end

    assign stall        = stall_s;
    assign flush        = excp_valid;
    assign new_pc_valid = (state_r == CTRL_REDIR);
    assign new_pc       = redir_pc_r;

`ifdef PIPE_CTRL_PERF_EN
    ctrl_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (|stall_s),
        .count (perf_stall_cnt)
    );

    ctrl_perf_cnt u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (excp_valid),
        .count (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Directed scenarios use
// fixed expected values; the random phase compares against a cycle model
// that tracks "is a redirect outstanding, and to where" as plain variables.
module tb_pipe_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_for_ifetch, stallreq_for_load, stallreq_for_ex, stallreq_for_mem;
    logic        excp_valid, br_valid, new_pc_ready;
    logic [31:0] excp_target, br_target;
    logic [5:0]  stall;
    logic        flush, new_pc_valid;
    logic [31:0] new_pc, perf_stall_cnt, perf_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_held;
    logic [31:0] m_tgt;
    logic [31:0] m_sc, m_fc;

    pipe_ctrl #(.STALL_W(6), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .stallreq_for_ifetch(stallreq_for_ifetch), .stallreq_for_load(stallreq_for_load),
        .stallreq_for_ex(stallreq_for_ex), .stallreq_for_mem(stallreq_for_mem),
        .excp_valid(excp_valid), .excp_target(excp_target),
        .br_valid(br_valid), .br_target(br_target), .new_pc_ready(new_pc_ready),
        .stall(stall), .flush(flush), .new_pc_valid(new_pc_valid), .new_pc(new_pc),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Expected freeze vector: count how many stages from PC upward are frozen.
    function automatic logic [5:0] exp_stall_f();
        int depth;
        depth = 0;
        if (excp_valid) return 6'd0;
        if (stallreq_for_mem)         depth = 5;
        else if (stallreq_for_ex)     depth = 4;
        else if (stallreq_for_load)   depth = 3;
        else if (stallreq_for_ifetch) depth = 2;
        if (m_held && depth < 2) depth = 2;
        return 6'((1 << depth) - 1);
    endfunction

    task automatic idle_inputs();
        rst = 1'b0;
        stallreq_for_ifetch = 1'b0; stallreq_for_load = 1'b0;
        stallreq_for_ex = 1'b0; stallreq_for_mem = 1'b0;
        excp_valid = 1'b0; br_valid = 1'b0; new_pc_ready = 1'b0;
        excp_target = 32'd0; br_target = 32'd0;
    endtask

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic tick();
        logic [5:0] es;
        @(posedge clk);
        es = exp_stall_f();
        if (rst) begin
            m_held = 1'b0; m_tgt = RST_PC; m_sc = 32'd0; m_fc = 32'd0;
        end else begin
            if (es != 6'd0) m_sc = m_sc + 32'd1;
            if (excp_valid) m_fc = m_fc + 32'd1;
            if (excp_valid) begin
                m_held = 1'b1; m_tgt = excp_target;
            end else if (m_held) begin
                if (new_pc_ready) begin m_held = 1'b0; m_tgt = RST_PC; end
            end else if (br_valid && !es[3]) begin
                m_held = 1'b1; m_tgt = br_target;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1'b1; tick(); rst = 1'b0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", new_pc_valid); end
        n_tests++; if (new_pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", new_pc, RST_PC); end
        n_tests++; if (stall !== 6'd0 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_stall_flush: got %b/%b want 000000/0", stall, flush); end
        n_tests++; if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt); end
    endtask

    task automatic test_stall_priority();
        idle_inputs(); stallreq_for_load = 1'b1; stallreq_for_mem = 1'b1; #1;
        n_tests++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL prio_load_mem: got %b want 011111", stall); end
        idle_inputs(); stallreq_for_ifetch = 1'b1; #1;
        n_tests++; if (stall !== 6'b000011) begin n_fail++; $display("FAIL prio_ifetch: got %b want 000011", stall); end
        idle_inputs(); stallreq_for_ex = 1'b1; stallreq_for_ifetch = 1'b1; #1;
        n_tests++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL prio_ex: got %b want 001111", stall); end
        idle_inputs(); stallreq_for_load = 1'b1; #1;
        n_tests++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL prio_load: got %b want 000111", stall); end
        tick(); idle_inputs(); #1;
    endtask

    task automatic test_branch_ready();
        idle_inputs(); br_valid = 1'b1; br_target = 32'h8000_0100; #1;
        n_tests++; if (new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL br_T_valid: got %0b want 0", new_pc_valid); end
        tick(); idle_inputs(); new_pc_ready = 1'b1; #1;
        n_tests++; if (new_pc_valid !== 1'b1 || new_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL br_T1_redir: got %0b/%h want 1/80000100", new_pc_valid, new_pc); end
        n_tests++; if (stall[1:0] !== 2'b11) begin n_fail++; $display("FAIL br_T1_stall: got %b want 11", stall[1:0]); end
        tick(); idle_inputs(); #1;
        n_tests++; if (new_pc_valid !== 1'b0 || stall !== 6'd0) begin n_fail++; $display("FAIL br_T2_idle: got %0b/%b want 0/000000", new_pc_valid, stall); end
    endtask

    task automatic test_branch_held();
        idle_inputs(); stallreq_for_ex = 1'b1; br_valid = 1'b1; br_target = 32'h8000_0240;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL brheld_stalled%0d: got %0b want 0", i, new_pc_valid); end
        end
        stallreq_for_ex = 1'b0; tick(); br_valid = 1'b0; #1;
        n_tests++; if (new_pc_valid !== 1'b1 || new_pc !== 32'h8000_0240) begin n_fail++; $display("FAIL brheld_accept: got %0b/%h want 1/80000240", new_pc_valid, new_pc); end
        new_pc_ready = 1'b1; tick(); idle_inputs(); #1;
    endtask

    task automatic test_excp_overwrite();
        idle_inputs(); br_valid = 1'b1; br_target = 32'h8000_0400; tick();
        idle_inputs(); excp_valid = 1'b1; excp_target = 32'hBFC0_0380; stallreq_for_mem = 1'b1; #1;
        n_tests++; if (flush !== 1'b1 || stall !== 6'd0) begin n_fail++; $display("FAIL excp_flush: got %0b/%b want 1/000000", flush, stall); end
        tick(); idle_inputs(); #1;
        n_tests++; if (new_pc_valid !== 1'b1 || new_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL excp_pc: got %0b/%h want 1/bfc00380", new_pc_valid, new_pc); end
        tick();
        n_tests++; if (new_pc_valid !== 1'b1 || new_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL excp_hold: got %0b/%h want 1/bfc00380", new_pc_valid, new_pc); end
        new_pc_ready = 1'b1; tick(); idle_inputs(); #1;
        n_tests++; if (new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL excp_release: got %0b want 0", new_pc_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        excp_valid = 1'b1; excp_target = 32'hBFC0_0380; br_valid = 1'b1; br_target = 32'h8000_0200;
        tick(); idle_inputs(); #1;
        n_tests++; if (new_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL simul_pc: got %h want bfc00380", new_pc); end
        n_tests++; if (perf_flush_cnt !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL simul_flushcnt: got %0d want %0d", perf_flush_cnt, PERF ? 1 : 0); end
        new_pc_ready = 1'b1; tick(); idle_inputs(); tick();
        n_tests++; if (new_pc_valid !== 1'b0) begin n_fail++; $display("FAIL simul_br_dropped: got %0b want 0", new_pc_valid); end
    endtask

    task automatic test_reset_mid_redir();
        idle_inputs(); stallreq_for_mem = 1'b1; tick();
        idle_inputs(); br_valid = 1'b1; br_target = 32'h8000_0800; tick();
        idle_inputs(); rst = 1'b1; tick(); rst = 1'b0; #1;
        n_tests++; if (new_pc_valid !== 1'b0 || new_pc !== RST_PC) begin n_fail++; $display("FAIL rstmid_redir: got %0b/%h want 0/%h", new_pc_valid, new_pc, RST_PC); end
        n_tests++; if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", perf_stall_cnt, perf_flush_cnt); end
    endtask

    task automatic test_random();
        logic [5:0] es;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst                 = ($urandom_range(0, 79) == 0);
            stallreq_for_ifetch = ($urandom_range(0, 4) == 0);
            stallreq_for_load   = ($urandom_range(0, 5) == 0);
            stallreq_for_ex     = ($urandom_range(0, 5) == 0);
            stallreq_for_mem    = ($urandom_range(0, 6) == 0);
            excp_valid          = ($urandom_range(0, 9) == 0);
            br_valid            = ($urandom_range(0, 2) == 0);
            new_pc_ready        = ($urandom_range(0, 1) == 0);
            excp_target         = $urandom;
            br_target           = $urandom;
            #1;
            es = exp_stall_f();
            n_tests++; if (stall !== es) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall, es); end
            n_tests++; if (flush !== excp_valid) begin n_fail++; $display("FAIL rnd_flush c%0d: got %0b want %0b", c, flush, excp_valid); end
            n_tests++; if (new_pc_valid !== m_held || new_pc !== m_tgt) begin n_fail++; $display("FAIL rnd_redir c%0d: got %0b/%h want %0b/%h", c, new_pc_valid, new_pc, m_held, m_tgt); end
            n_tests++; if (perf_stall_cnt !== (PERF ? m_sc : 32'd0) || perf_flush_cnt !== (PERF ? m_fc : 32'd0)) begin
                n_fail++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, perf_stall_cnt, perf_flush_cnt, PERF ? m_sc : 32'd0, PERF ? m_fc : 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        m_held = 1'b0; m_tgt = RST_PC; m_sc = 32'd0; m_fc = 32'd0;
        idle_inputs();
        #2;
        test_reset();
        test_stall_priority();
        test_branch_ready();
        test_branch_held();
        test_excp_overwrite();
        test_simultaneous();
        test_reset_mid_redir();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
